// File: rtl/m_mem_arb_pkg.sv
// rtl/m_mem_arb_pkg.sv - shared types and constants for the IF/LSU memory arbiter
//
// Contents:
//   arb_state_t      arbiter FSM state encoding
//   OWN_IF, OWN_LSU  owner encoding used by owner_o and the winner select
//   ARB_ADDR_W, ARB_DATA_W  default address / data widths
package m_mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        IF_GNT   = 2'd1,
        LSU_GNT  = 2'd2,
        IF_DRAIN = 2'd3
    } arb_state_t;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int ARB_ADDR_W = 32;
    localparam int ARB_DATA_W = 32;

endpackage

// File: rtl/m_arb_pick.sv
// rtl/m_arb_pick.sv - combinational winner select between fetch and LSU requests
//
// Configuration macro: ARB_ROUND_ROBIN_EN
//   defined   : on contention, grant the requester that was not served last
//   undefined : fixed priority, LSU wins over IF
//
// Ports:
//   if_req       in   effective fetch request (already masked by flush)
//   lsu_req      in   LSU request
//   last_owner   in   owner of the most recent grant (OWN_IF / OWN_LSU)
//   grant_valid  out  at least one request present
//   grant_owner  out  winning requester (OWN_IF / OWN_LSU)
module m_arb_pick
    import m_mem_arb_pkg::*;
(
    input  logic if_req,
    input  logic lsu_req,
    input  logic last_owner,
    output logic grant_valid,
    output logic grant_owner
);

    assign grant_valid = if_req | lsu_req;

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_owner = OWN_IF;
        if (if_req && lsu_req) begin
            // Alternate: serve whoever did not get the previous grant.
            grant_owner = (last_owner == OWN_LSU) ? OWN_IF : OWN_LSU;
        end else if (lsu_req) begin
            grant_owner = OWN_LSU;
        end
    end
`else
    // Fixed priority needs no history.
    logic unused_last_owner;
    assign unused_last_owner = last_owner;

    always_comb begin
        grant_owner = OWN_IF;
        if (lsu_req) begin
            grant_owner = OWN_LSU;
        end
    end
`endif

endmodule

// File: rtl/m_mem_arbiter.sv
// rtl/m_mem_arbiter.sv - arbitrates the single memory port between fetch and LSU
//
// Configuration macro: ARB_ROUND_ROBIN_EN (round-robin on contention; default is
// fixed LSU priority), implemented inside m_arb_pick.
//
// Ports:
//   clk, rst                    clock, asynchronous active-high reset
//   if_req_i, if_addr_i         fetch request and address
//   if_flush_i                  redirect; kills the pending or in-flight fetch
//   if_ack_o, if_rdata_o        fetch completion pulse and data
//   lsu_req_i, lsu_we_i, lsu_be_i, lsu_addr_i, lsu_wdata_i   LSU request and payload
//   lsu_ack_o, lsu_rdata_o      LSU completion pulse and load data
//   mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o   bus request, latched payload
//   mem_ack_i, mem_rdata_i      bus completion pulse and read data
//   busy_o                      transaction in progress
//   owner_o                     current or last owner (0 = IF, 1 = LSU)
module m_mem_arbiter
    import m_mem_arb_pkg::*;
#(
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int DATA_W = ARB_DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                if_req_i,
    input  logic [ADDR_W-1:0]   if_addr_i,
    input  logic                if_flush_i,
    output logic                if_ack_o,
    output logic [DATA_W-1:0]   if_rdata_o,
    input  logic                lsu_req_i,
    input  logic                lsu_we_i,
    input  logic [DATA_W/8-1:0] lsu_be_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_ack_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    output logic                mem_req_o,
    output logic                mem_we_o,
    output logic [DATA_W/8-1:0] mem_be_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic                mem_ack_i,
    input  logic [DATA_W-1:0]   mem_rdata_i,
    output logic                busy_o,
    output logic                owner_o
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t state;
    logic       if_req_eff;
    logic       pick_valid;
    logic       pick_owner;

    // A fetch that is being redirected this cycle must not win the bus.
    assign if_req_eff = if_req_i & ~if_flush_i;

    m_arb_pick u_pick (
        .if_req      (if_req_eff),
        .lsu_req     (lsu_req_i),
        .last_owner  (owner_o),
        .grant_valid (pick_valid),
        .grant_owner (pick_owner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_be_o    <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            owner_o     <= OWN_IF;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner_o   <= pick_owner;
                        mem_req_o <= 1'b1;
                        if (pick_owner == OWN_LSU) begin
                            mem_we_o    <= lsu_we_i;
                            mem_be_o    <= lsu_be_i;
                            mem_addr_o  <= lsu_addr_i;
                            mem_wdata_o <= lsu_wdata_i;
                            state       <= LSU_GNT;
                        end else begin
                            mem_we_o    <= 1'b0;
                            mem_be_o    <= {BE_W{1'b1}};
                            mem_addr_o  <= if_addr_i;
                            mem_wdata_o <= '0;
                            state       <= IF_GNT;
                        end
                    end
                end
                IF_GNT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end else if (if_flush_i) begin
                        // Bus transaction cannot be cancelled; keep it up and drop its response.
                        state <= IF_DRAIN;
                    end
                end
                IF_DRAIN: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                LSU_GNT: begin
                    if (mem_ack_i) begin
                        mem_req_o <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    mem_req_o <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // A flush coinciding with the bus ack suppresses the fetch ack.
    assign if_ack_o    = mem_ack_i & (state == IF_GNT) & ~if_flush_i;
    assign lsu_ack_o   = mem_ack_i & (state == LSU_GNT);
    assign if_rdata_o  = mem_rdata_i;
    assign lsu_rdata_o = mem_rdata_i;
    assign busy_o      = (state != IDLE);

endmodule

// File: tb/tb_m_mem_arbiter.sv
// tb/tb_m_mem_arbiter.sv - directed self-checking bench for m_mem_arbiter
module tb_m_mem_arbiter;
    import m_mem_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req_i;
    logic [31:0] if_addr_i;
    logic        if_flush_i;
    logic        if_ack_o;
    logic [31:0] if_rdata_o;
    logic        lsu_req_i;
    logic        lsu_we_i;
    logic [3:0]  lsu_be_i;
    logic [31:0] lsu_addr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ack_o;
    logic [31:0] lsu_rdata_o;
    logic        mem_req_o;
    logic        mem_we_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_wdata_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        busy_o;
    logic        owner_o;

    int n_checks;
    int n_fail;

    m_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_ack_o    (if_ack_o),
        .if_rdata_o  (if_rdata_o),
        .lsu_req_i   (lsu_req_i),
        .lsu_we_i    (lsu_we_i),
        .lsu_be_i    (lsu_be_i),
        .lsu_addr_i  (lsu_addr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_ack_o   (lsu_ack_o),
        .lsu_rdata_o (lsu_rdata_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_be_o    (mem_be_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_ack_i   (mem_ack_i),
        .mem_rdata_i (mem_rdata_i),
        .busy_o      (busy_o),
        .owner_o     (owner_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change 1 unit after the rising edge; checks run 4 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        if_req_i = 1'b0; if_addr_i = '0; if_flush_i = 1'b0;
        lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
        mem_ack_i = 1'b0; mem_rdata_i = '0;
        next_cycle(); next_cycle();
        #4;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} !== 70'd0) begin
            n_fail++;
            $display("FAIL reset_payload: req=%0h we=%0h be=%0h addr=%0h wdata=%0h expected all 0",
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o);
        end
        n_checks++;
        if ({busy_o, owner_o, if_ack_o, lsu_ack_o} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_status: busy=%0h owner=%0h if_ack=%0h lsu_ack=%0h expected 0",
                     busy_o, owner_o, if_ack_o, lsu_ack_o);
        end
        next_cycle();
        rst = 1'b0;
        next_cycle();
    endtask

    task automatic test_if_fetch();
        // T
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h100;
        #4;
        n_checks++;
        if (mem_req_o !== 1'b0) begin
            n_fail++; $display("FAIL if_fetch_t0_req: mem_req_o=%0h expected 0", mem_req_o);
        end
        // T+1
        next_cycle();
        #4;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, owner_o} !== {1'b1, 1'b0, 4'hF, 32'h100, OWN_IF}) begin
            n_fail++;
            $display("FAIL if_fetch_grant: req=%0h we=%0h be=%0h addr=%0h owner=%0h expected 1 0 f 100 0",
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, owner_o);
        end
        n_checks++;
        if (if_ack_o !== 1'b0) begin
            n_fail++; $display("FAIL if_fetch_early_ack: if_ack_o=%0h expected 0", if_ack_o);
        end
        // T+2
        next_cycle();
        mem_ack_i = 1'b1; mem_rdata_i = 32'h1234_5678;
        #4;
        n_checks++;
        if ({if_ack_o, lsu_ack_o, if_rdata_o} !== {1'b1, 1'b0, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL if_fetch_ack: if_ack=%0h lsu_ack=%0h rdata=%0h expected 1 0 12345678",
                     if_ack_o, lsu_ack_o, if_rdata_o);
        end
        // T+3
        next_cycle();
        mem_ack_i = 1'b0; if_req_i = 1'b0;
        #4;
        n_checks++;
        if ({busy_o, mem_req_o, if_ack_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL if_fetch_done: busy=%0h req=%0h if_ack=%0h expected 0 0 0",
                     busy_o, mem_req_o, if_ack_o);
        end
    endtask

    task automatic test_contention();
        logic exp_own;
        logic [31:0] exp_addr;
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h300;
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'h5;
        lsu_addr_i = 32'h200; lsu_wdata_i = 32'hA5A5_0001;
        for (int k = 0; k < 4; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_own = (k % 2 == 0) ? OWN_LSU : OWN_IF;
`else
            exp_own = OWN_LSU;
`endif
            exp_addr = (exp_own == OWN_LSU) ? 32'h200 : 32'h300;
            // grant cycle, acked immediately
            next_cycle();
            mem_ack_i = 1'b1;
            #4;
            n_checks++;
            if ({mem_req_o, owner_o, mem_addr_o} !== {1'b1, exp_own, exp_addr}) begin
                n_fail++;
                $display("FAIL contention_grant%0d: req=%0h owner=%0h addr=%0h expected 1 %0h %0h",
                         k, mem_req_o, owner_o, mem_addr_o, exp_own, exp_addr);
            end
            n_checks++;
            if ({lsu_ack_o, if_ack_o} !== {exp_own, ~exp_own}) begin
                n_fail++;
                $display("FAIL contention_ack%0d: lsu_ack=%0h if_ack=%0h expected %0h %0h",
                         k, lsu_ack_o, if_ack_o, exp_own, ~exp_own);
            end
            // back in IDLE
            next_cycle();
            mem_ack_i = 1'b0;
            if (k == 3) lsu_req_i = 1'b0;
            #4;
            n_checks++;
            if (busy_o !== 1'b0) begin
                n_fail++; $display("FAIL contention_idle%0d: busy=%0h expected 0", k, busy_o);
            end
        end
        // LSU gone: fetch granted alone
        next_cycle();
        #4;
        n_checks++;
        if ({mem_req_o, owner_o, mem_addr_o, mem_we_o, mem_be_o} !== {1'b1, OWN_IF, 32'h300, 1'b0, 4'hF}) begin
            n_fail++;
            $display("FAIL contention_if_after: req=%0h owner=%0h addr=%0h we=%0h be=%0h expected 1 0 300 0 f",
                     mem_req_o, owner_o, mem_addr_o, mem_we_o, mem_be_o);
        end
        next_cycle();
        mem_ack_i = 1'b1;
        #4;
        n_checks++;
        if (if_ack_o !== 1'b1) begin
            n_fail++; $display("FAIL contention_if_ack: if_ack_o=%0h expected 1", if_ack_o);
        end
        next_cycle();
        mem_ack_i = 1'b0; if_req_i = 1'b0; lsu_we_i = 1'b0;
        next_cycle();
    endtask

    task automatic test_flush_in_gnt();
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h400;
        // T+1: granted, redirect arrives
        next_cycle();
        if_flush_i = 1'b1; if_req_i = 1'b0;
        #4;
        n_checks++;
        if ({mem_req_o, mem_addr_o, if_ack_o} !== {1'b1, 32'h400, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_t1: req=%0h addr=%0h if_ack=%0h expected 1 400 0", mem_req_o, mem_addr_o, if_ack_o);
        end
        // T+2, T+3: draining; a second flush at T+3 must be ignored
        for (int c = 2; c <= 3; c++) begin
            next_cycle();
            if_flush_i = (c == 3);
            #4;
            n_checks++;
            if ({mem_req_o, busy_o, mem_addr_o, mem_be_o} !== {1'b1, 1'b1, 32'h400, 4'hF}) begin
                n_fail++;
                $display("FAIL flush_drain_t%0d: req=%0h busy=%0h addr=%0h be=%0h expected 1 1 400 f",
                         c, mem_req_o, busy_o, mem_addr_o, mem_be_o);
            end
        end
        // T+4: bus response arrives and is dropped
        next_cycle();
        if_flush_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_0004;
        #4;
        n_checks++;
        if ({if_ack_o, lsu_ack_o, mem_req_o, mem_addr_o} !== {1'b0, 1'b0, 1'b1, 32'h400}) begin
            n_fail++;
            $display("FAIL flush_t4: if_ack=%0h lsu_ack=%0h req=%0h addr=%0h expected 0 0 1 400",
                     if_ack_o, lsu_ack_o, mem_req_o, mem_addr_o);
        end
        // T+5
        next_cycle();
        mem_ack_i = 1'b0;
        #4;
        n_checks++;
        if ({busy_o, mem_req_o} !== 2'b00) begin
            n_fail++; $display("FAIL flush_t5: busy=%0h req=%0h expected 0 0", busy_o, mem_req_o);
        end
    endtask

    task automatic test_flush_edges();
        // flush coincident with bus ack
        next_cycle();
        if_req_i = 1'b1; if_addr_i = 32'h500;
        next_cycle();
        mem_ack_i = 1'b1; if_flush_i = 1'b1; if_req_i = 1'b0;
        #4;
        n_checks++;
        if ({if_ack_o, mem_req_o} !== 2'b01) begin
            n_fail++; $display("FAIL flush_coincident: if_ack=%0h req=%0h expected 0 1", if_ack_o, mem_req_o);
        end
        next_cycle();
        mem_ack_i = 1'b0; if_flush_i = 1'b0;
        #4;
        n_checks++;
        if (busy_o !== 1'b0) begin
            n_fail++; $display("FAIL flush_coincident_idle: busy=%0h expected 0", busy_o);
        end
        // flush together with a request in IDLE: no grant
        next_cycle();
        if_req_i = 1'b1; if_flush_i = 1'b1; if_addr_i = 32'h600;
        next_cycle();
        if_req_i = 1'b0; if_flush_i = 1'b0;
        #4;
        n_checks++;
        if ({mem_req_o, busy_o} !== 2'b00) begin
            n_fail++; $display("FAIL flush_idle: req=%0h busy=%0h expected 0 0", mem_req_o, busy_o);
        end
        // stray bus ack in IDLE
        next_cycle();
        mem_ack_i = 1'b1;
        #4;
        n_checks++;
        if ({if_ack_o, lsu_ack_o, busy_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL idle_ack: if_ack=%0h lsu_ack=%0h busy=%0h expected 0 0 0", if_ack_o, lsu_ack_o, busy_o);
        end
        next_cycle();
        mem_ack_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        next_cycle();
        lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_be_i = 4'h3;
        lsu_addr_i = 32'h700; lsu_wdata_i = 32'hDEAD_BEEF;
        next_cycle();
        #2;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, owner_o} !== {1'b1, 1'b1, 4'h3, 32'hDEAD_BEEF, OWN_LSU}) begin
            n_fail++;
            $display("FAIL store_grant: req=%0h we=%0h be=%0h wdata=%0h owner=%0h expected 1 1 3 deadbeef 1",
                     mem_req_o, mem_we_o, mem_be_o, mem_wdata_o, owner_o);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, owner_o, busy_o} !== 72'd0) begin
            n_fail++;
            $display("FAIL async_reset: req=%0h we=%0h be=%0h addr=%0h wdata=%0h owner=%0h busy=%0h expected all 0",
                     mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o, owner_o, busy_o);
        end
        lsu_req_i = 1'b0;
        next_cycle();
        rst = 1'b0; mem_ack_i = 1'b1;
        #4;
        n_checks++;
        if ({lsu_ack_o, busy_o, mem_req_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL late_ack_after_reset: lsu_ack=%0h busy=%0h req=%0h expected 0 0 0",
                     lsu_ack_o, busy_o, mem_req_o);
        end
        next_cycle();
        mem_ack_i = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_if_fetch();
        test_contention();
        test_flush_in_gnt();
        test_flush_edges();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m_mem_arbiter.md
# m_mem_arbiter

Two-requester arbiter sharing the core's single memory port between instruction fetch (IF) and the load/store unit (LSU). It sits between the fetch stage / LSU and the memory bus, and sequences one transaction at a time using a req/ack handshake. It latches each transaction's payload at grant, so the bus stays stable while the requesters stall. It also absorbs pipeline redirects by draining a fetch that is already in flight and discarding its response.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- if_req_i  in  1  fetch request; held with if_addr_i until if_ack_o or if_flush_i
- if_addr_i  in  ADDR_W  fetch address
- if_flush_i  in  1  redirect (exe/csr pc request or wfi); kills the pending or in-flight fetch
- if_ack_o  out  1  fetch complete, one-cycle pulse
- if_rdata_o  out  DATA_W  fetch data, valid with if_ack_o
- lsu_req_i  in  1  LSU request; held with its payload until lsu_ack_o
- lsu_we_i  in  1  store when 1
- lsu_be_i  in  DATA_W/8  byte enables
- lsu_addr_i  in  ADDR_W  LSU address
- lsu_wdata_i  in  DATA_W  store data
- lsu_ack_o  out  1  LSU transaction complete, one-cycle pulse
- lsu_rdata_o  out  DATA_W  load data, valid with lsu_ack_o
- mem_req_o  out  1  bus request, held until mem_ack_i
- mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o  out  1/DATA_W/8/ADDR_W/DATA_W  latched payload
- mem_ack_i  in  1  bus completion pulse
- mem_rdata_i  in  DATA_W  bus read data, valid with mem_ack_i
- busy_o  out  1  FSM not IDLE
- owner_o  out  1  current or last owner: 0 = IF, 1 = LSU

## Operation
- States:
  - IDLE: no transaction.
  - IF_GNT: fetch transaction on the bus.
  - LSU_GNT: LSU transaction on the bus.
  - IF_DRAIN: flushed fetch still on the bus; its response will be dropped.
- IDLE:
  - Compute the effective fetch request as if_req_i & ~if_flush_i.
  - If any request is present, pick a winner, latch its payload into the mem_* registers and move to the matching GNT state.
  - A fetch always latches we=0 and be=all-ones.
- Default arbitration: the LSU has fixed priority over IF.
- IF_GNT:
  - mem_ack_i & ~if_flush_i: go to IDLE and pulse if_ack_o.
  - mem_ack_i & if_flush_i: go to IDLE with no ack; the flush wins.
  - if_flush_i without mem_ack_i: go to IF_DRAIN.
- IF_DRAIN: mem_req_o stays high. On mem_ack_i, go to IDLE with no if_ack_o. Further flushes are ignored.
- LSU_GNT: on mem_ack_i, go to IDLE and pulse lsu_ack_o. if_flush_i has no effect on the LSU.
- Acks are combinational: if_ack_o / lsu_ack_o = mem_ack_i while in the owner's GNT state. rdata outputs pass mem_rdata_i through.
- A mem_ack_i arriving in IDLE is ignored.
- Reset values: state IDLE, mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0, owner_o=0, busy_o=0, both acks 0.

## Timing
- Request seen in IDLE at cycle T: mem_req_o=1 and payload valid at T+1.
- Earliest mem_ack_i is T+1, with the requester's ack in the same cycle.
- The FSM is back in IDLE at T+2, so the next grant is visible at T+3. Peak throughput is one transaction per 2 cycles.
- Requesters deassert req the cycle after their ack. The arbiter never re-grants a request in the cycle its ack fires.
- mem_* payload is constant from grant until mem_ack_i, including through IF_DRAIN.
- Asynchronous rst mid-transaction drops mem_req_o immediately. Any later mem_ack_i is ignored (state is IDLE).

## Configuration
- Macro: ARB_ROUND_ROBIN_EN.
- Defined: when both requests are present in IDLE, grant the requester that is not in owner_o (last served). A single requester is granted regardless. owner_o is updated at every grant.
- Undefined: fixed LSU priority, with no fairness state beyond owner_o.

## Structure
- Shared package m_mem_arb_pkg holds:
  - state enum arb_state_t {IDLE, IF_GNT, LSU_GNT, IF_DRAIN};
  - owner constants OWN_IF=1'b0 and OWN_LSU=1'b1;
  - default widths.
- One sub-module is natural: m_arb_pick, the combinational winner select between fixed priority and round-robin, so it can be unit-tested separately.
- The FSM and payload registers stay in the top module.

## Test plan
- IF-only fetch: if_req_i=1, addr 0x100, mem_ack_i at T+2 → mem_req_o at T+1 with addr 0x100, we=0, be=0xF; if_ack_o at T+2; busy_o drops at T+3.
- Contention with default config: both requests at T → LSU granted (owner_o=1); IF granted at T+3 after the LSU ack at T+1.
- Contention with ARB_ROUND_ROBIN_EN, both requests held for 4 transactions → grants alternate LSU, IF, LSU, IF.
- Flush in IF_GNT: if_flush_i at T+1, mem_ack_i at T+4 → mem_req_o held through T+4 with the original addr; if_ack_o never asserts; IDLE at T+5.
- Flush coincident with mem_ack_i in IF_GNT → no if_ack_o. Flush with if_req_i in IDLE and no LSU request → no grant, mem_req_o stays 0.
- Store 0xDEADBEEF, be=0x3, with rst asserted at T+1 → all mem_* outputs reset asynchronously; a subsequent mem_ack_i produces no lsu_ack_o.
